// File: rtl/set_job_sched_if.sv
// Job-scheduler bus: requester side (req/operands/ack), engine side (start/operands/result)
// and response side. The scheduler uses the slave modport; the job sources and engine use master.
interface set_job_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [24*NREQ-1:0] req_central;
  logic [12*NREQ-1:0] req_radius;
  logic [2*NREQ-1:0]  req_mode;
  logic [NREQ-1:0]    req_ack;
  logic               eng_en;
  logic [23:0]        eng_central;
  logic [11:0]        eng_radius;
  logic [1:0]         eng_mode;
  logic               eng_valid;
  logic [7:0]         eng_candidate;
  logic               rsp_valid;
  logic [1:0]         rsp_id;
  logic [7:0]         rsp_candidate;
  logic               rsp_err;
  logic               sched_busy;
  logic [15:0]        jobs_done;

  modport master (
    output req, req_central, req_radius, req_mode, eng_valid, eng_candidate,
    input  req_ack, eng_en, eng_central, eng_radius, eng_mode,
           rsp_valid, rsp_id, rsp_candidate, rsp_err, sched_busy, jobs_done
  );

  modport slave (
    input  req, req_central, req_radius, req_mode, eng_valid, eng_candidate,
    output req_ack, eng_en, eng_central, eng_radius, eng_mode,
           rsp_valid, rsp_id, rsp_candidate, rsp_err, sched_busy, jobs_done
  );
endinterface

// File: rtl/set_job_sched.sv
// set_job_sched: round-robin scheduler sharing one SET candidate-counting engine among NREQ requesters.
// Optional engine watchdog is compiled in when SET_SCHED_WDOG_EN is defined.
module set_job_sched #(
  parameter int NREQ        = 2,
  parameter int WDOG_CYCLES = 200
) (
  input  logic           clk,
  input  logic           rst,
  set_job_sched_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [1:0]      r_rr;
  logic [1:0]      r_gnt;
  logic [NREQ-1:0] r_req_ack;
  logic            r_eng_en;
  logic [23:0]     r_eng_central;
  logic [11:0]     r_eng_radius;
  logic [1:0]      r_eng_mode;
  logic            r_rsp_valid;
  logic [1:0]      r_rsp_id;
  logic [7:0]      r_rsp_cand;
  logic            r_rsp_err;
  logic            r_busy;
  logic [15:0]     r_jobs_done;

  logic            w_found;
  logic [1:0]      w_gnt;
  logic [NREQ-1:0] w_ack;
  logic [23:0]     w_central;
  logic [11:0]     w_radius;
  logic [1:0]      w_mode;
  logic            w_timeout;

  function automatic logic [1:0] next_rr(input logic [1:0] g);
    next_rr = (int'(g) + 1 >= NREQ) ? 2'd0 : g + 2'd1;
  endfunction

  // First pending requester at or above the rr pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && bus.req[i] && (i == (int'(r_rr) + k) % NREQ)) begin
          w_found = 1'b1;
          w_gnt   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    w_ack     = '0;
    w_central = '0;
    w_radius  = '0;
    w_mode    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == 2'(i)) begin
        w_ack[i]  = 1'b1;
        w_central = bus.req_central[24*i +: 24];
        w_radius  = bus.req_radius[12*i +: 12];
        w_mode    = bus.req_mode[2*i +: 2];
      end
    end
  end

`ifdef SET_SCHED_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
  logic [15:0] r_wdog;

  // Counts WAIT cycles; the final WAIT cycle is the one where the count is WDOG_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  assign w_timeout = (r_wdog == WDOG_LAST);
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYCLES > 0);
  assign w_timeout     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr          <= '0;
      r_gnt         <= '0;
      r_req_ack     <= '0;
      r_eng_en      <= 1'b0;
      r_eng_central <= '0;
      r_eng_radius  <= '0;
      r_eng_mode    <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_cand    <= '0;
      r_rsp_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_jobs_done   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt         <= w_gnt;
            r_eng_central <= w_central;
            r_eng_radius  <= w_radius;
            r_eng_mode    <= w_mode;
            r_req_ack     <= w_ack;
            r_eng_en      <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_req_ack <= '0;
          r_eng_en  <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the watchdog's last cycle takes priority over the timeout.
          if (bus.eng_valid || w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_gnt;
            r_rsp_cand  <= bus.eng_valid ? bus.eng_candidate : 8'd0;
            r_rsp_err   <= w_timeout && !bus.eng_valid;
            r_jobs_done <= r_jobs_done + 16'd1;
            r_rr        <= next_rr(r_gnt);
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ack       = r_req_ack;
  assign bus.eng_en        = r_eng_en;
  assign bus.eng_central   = r_eng_central;
  assign bus.eng_radius    = r_eng_radius;
  assign bus.eng_mode      = r_eng_mode;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_candidate = r_rsp_cand;
  assign bus.rsp_err       = r_rsp_err;
  assign bus.sched_busy    = r_busy;
  assign bus.jobs_done     = r_jobs_done;
endmodule
